// File: rtl/alu_r_seq.sv
// Handshaked RV32I/RV32M R-type ALU: base ops and M-extension early-outs finish in one cycle.
// MUL/DIV families iterate one bit per cycle over XLEN cycles.
module alu_r_seq #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            iFLUSH,
    input  logic            iVALID,
    output logic            oREADY,
    input  logic [31:0]     iIR,
    input  logic [XLEN-1:0] iRS1,
    input  logic [XLEN-1:0] iRS2,
    output logic            oVALID,
    input  logic            iREADY,
    output logic [4:0]      oRD,
    output logic [XLEN-1:0] oRESULT,
    output logic            oILLEGAL
);

    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} aluStateT;

    aluStateT state, nextState;

    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic            accept, isBase, isM, isDivOp, divZero, divOvf, earlyOut, iterStart;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] quickRes;
    logic            quickIll;
    logic            aSigned, bSigned, aNeg, bNeg;
    logic [XLEN-1:0] aMag, bMag;
    logic            unusedIr;

    // Iteration state shared by multiply and divide: accHi/accLo hold the
    // partial product, or remainder/quotient, opnd the multiplicand or divisor.
    logic [XLEN-1:0] accHi, accLo, opnd;
    logic [2:0]      mOp;
    logic            negX, negA;
    logic [SHW-1:0]  cnt;
    logic            lastStep;

    logic [XLEN:0]     mulSum, divShift, divDiff;
    logic              divFit;
    logic [XLEN-1:0]   stepHi, stepLo, quo, rem;
    logic [2*XLEN-1:0] prodFull, prodSigned;
    logic [XLEN-1:0]   finalRes;

    assign funct7    = iIR[31:25];
    assign funct3    = iIR[14:12];
    assign unusedIr  = ^{iIR[24:15], iIR[6:0]};
    assign shamt     = iRS2[SHW-1:0];

    assign oVALID    = (state == DONE);
    assign oREADY    = (state == IDLE) | ((state == DONE) & iREADY);
    assign accept    = iVALID & oREADY & ~iFLUSH;

    assign isBase    = (funct7 == 7'h00) |
                       ((funct7 == 7'h20) & ((funct3 == 3'd0) | (funct3 == 3'd5)));
    assign isM       = (funct7 == 7'h01) & ENABLE_M;
    assign isDivOp   = funct3[2];
    assign divZero   = (iRS2 == '0);
    assign divOvf    = ~funct3[0] & (iRS1 == {1'b1, {(XLEN-1){1'b0}}}) & (iRS2 == '1);
    assign earlyOut  = isM & isDivOp & (divZero | divOvf);
    assign iterStart = accept & isM & ~earlyOut;

    // Single-cycle results: base ops, divide early-outs and illegal encodings.
    always_comb begin
        quickRes = '0;
        quickIll = 1'b0;
        if (isBase) begin
            unique case (funct3)
                3'd0: quickRes = funct7[5] ? (iRS1 - iRS2) : (iRS1 + iRS2);
                3'd1: quickRes = iRS1 << shamt;
                3'd2: quickRes = {{(XLEN-1){1'b0}}, ($signed(iRS1) < $signed(iRS2))};
                3'd3: quickRes = {{(XLEN-1){1'b0}}, (iRS1 < iRS2)};
                3'd4: quickRes = iRS1 ^ iRS2;
                3'd5: quickRes = funct7[5] ? XLEN'($signed(iRS1) >>> shamt) : (iRS1 >> shamt);
                3'd6: quickRes = iRS1 | iRS2;
                default: quickRes = iRS1 & iRS2;
            endcase
        end else if (isM) begin
            if (divZero)
                quickRes = funct3[1] ? iRS1 : '1;
            else
                quickRes = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            quickIll = 1'b1;
        end
    end

    // Operand signedness: MULH s*s, MULHSU s*u, DIV/REM signed.
    always_comb begin
        aSigned = (funct3 == 3'd1) | (funct3 == 3'd2) | (funct3 == 3'd4) | (funct3 == 3'd6);
        bSigned = (funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6);
        aNeg    = aSigned & iRS1[XLEN-1];
        bNeg    = bSigned & iRS2[XLEN-1];
        aMag    = aNeg ? (~iRS1 + 1'b1) : iRS1;
        bMag    = bNeg ? (~iRS2 + 1'b1) : iRS2;
    end

    assign lastStep = (state == BUSY) && (cnt == SHW'(XLEN-1));

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
        divShift = {accHi, accLo[XLEN-1]};
        divDiff  = divShift - {1'b0, opnd};
        divFit   = ~divDiff[XLEN];
        if (mOp[2]) begin
            stepHi = divFit ? divDiff[XLEN-1:0] : divShift[XLEN-1:0];
            stepLo = {accLo[XLEN-2:0], divFit};
        end else begin
            stepHi = mulSum[XLEN:1];
            stepLo = {mulSum[0], accLo[XLEN-1:1]};
        end
        // Sign fixup folded into the final step so the result lands with the last iteration.
        prodFull   = {stepHi, stepLo};
        prodSigned = negX ? (~prodFull + 1'b1) : prodFull;
        quo        = negX ? (~stepLo + 1'b1) : stepLo;
        rem        = negA ? (~stepHi + 1'b1) : stepHi;
        unique case (mOp)
            3'd0:       finalRes = prodSigned[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       finalRes = prodSigned[2*XLEN-1:XLEN];
            3'd4, 3'd5: finalRes = quo;
            default:    finalRes = rem;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (accept) nextState = iterStart ? BUSY : DONE;
            BUSY: if (lastStep) nextState = DONE;
            DONE: begin
                if (accept)
                    nextState = iterStart ? BUSY : DONE;
                else if (iREADY)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (iFLUSH)
            nextState = IDLE;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oRD      <= '0;
            oRESULT  <= '0;
            oILLEGAL <= 1'b0;
            accHi    <= '0;
            accLo    <= '0;
            opnd     <= '0;
            mOp      <= '0;
            negX     <= 1'b0;
            negA     <= 1'b0;
            cnt      <= '0;
        end else if (!iFLUSH) begin
            if (accept) begin
                oRD <= iIR[11:7];
                if (iterStart) begin
                    mOp   <= funct3;
                    negX  <= aNeg ^ bNeg;
                    negA  <= aNeg;
                    cnt   <= '0;
                    accHi <= '0;
                    accLo <= isDivOp ? aMag : bMag;
                    opnd  <= isDivOp ? bMag : aMag;
                end else begin
                    oRESULT  <= quickRes;
                    oILLEGAL <= quickIll;
                end
            end else if (state == BUSY) begin
                accHi <= stepHi;
                accLo <= stepLo;
                cnt   <= cnt + 1'b1;
                if (lastStep) begin
                    oRESULT  <= finalRes;
                    oILLEGAL <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_r_seq.sv
// Directed-vector bench for alu_r_seq: base ops, M ops, early-outs, handshake, flush and reset.
module tb_alu_r_seq;

    localparam int unsigned XLEN = 32;

    logic            iCLK = 1'b0;
    logic            iRST_N, iFLUSH, iVALID, iREADY;
    logic            oREADY, oVALID, oILLEGAL;
    logic [31:0]     iIR;
    logic [XLEN-1:0] iRS1, iRS2, oRESULT;
    logic [4:0]      oRD;

    int unsigned total = 0;
    int unsigned bad   = 0;

    alu_r_seq #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iFLUSH(iFLUSH), .iVALID(iVALID), .oREADY(oREADY),
        .iIR(iIR), .iRS1(iRS1), .iRS2(iRS2), .oVALID(oVALID), .iREADY(iREADY),
        .oRD(oRD), .oRESULT(oRESULT), .oILLEGAL(oILLEGAL)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rIr(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        rIr = {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // Issue one op from IDLE, hold the result with iREADY low, then retire it.
    task automatic runOp(input string tag, input logic [31:0] ir, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input logic expIll,
                         input int expLat);
        int lat;
        @(negedge iCLK);
        check({tag, "_rdyIn"}, {31'd0, oREADY}, 32'd1);
        iIR = ir; iRS1 = a; iRS2 = b; iVALID = 1'b1; iREADY = 1'b0;
        @(posedge iCLK); #1;
        iVALID = 1'b0; iRS1 = ~a; iRS2 = ~b; iIR = '0;
        lat = 1;
        while (!oVALID && lat < 100) begin
            @(posedge iCLK); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, expLat);
        check({tag, "_res"}, oRESULT, expRes);
        check({tag, "_ill"}, {31'd0, oILLEGAL}, {31'd0, expIll});
        check({tag, "_rd"}, {27'd0, oRD}, {27'd0, ir[11:7]});
        @(negedge iCLK); iREADY = 1'b1;
        @(posedge iCLK); #1;
        check({tag, "_retire"}, {31'd0, oVALID}, 32'd0);
        iREADY = 1'b0;
    endtask

    initial begin
        int seen;
        logic [31:0] bbA [4];
        iRST_N = 1'b0; iFLUSH = 1'b0; iVALID = 1'b0; iREADY = 1'b0;
        iIR = '0; iRS1 = '0; iRS2 = '0;
        #22;
        check("rst_valid", {31'd0, oVALID}, 32'd0);
        check("rst_ready", {31'd0, oREADY}, 32'd1);
        check("rst_res", oRESULT, 32'd0);
        check("rst_rd", {27'd0, oRD}, 32'd0);
        check("rst_ill", {31'd0, oILLEGAL}, 32'd0);
        @(negedge iCLK); iRST_N = 1'b1;

        runOp("add",    rIr(7'h00, 3'd0, 5'd3),  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1);
        runOp("sub",    rIr(7'h20, 3'd0, 5'd4),  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1);
        runOp("sra",    rIr(7'h20, 3'd5, 5'd5),  32'h80000000, 32'd35,       32'hF0000000, 1'b0, 1);
        runOp("srl",    rIr(7'h00, 3'd5, 5'd6),  32'h80000000, 32'd35,       32'h10000000, 1'b0, 1);
        runOp("sll",    rIr(7'h00, 3'd1, 5'd7),  32'd1,        32'd33,       32'd2,        1'b0, 1);
        runOp("slt",    rIr(7'h00, 3'd2, 5'd8),  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
        runOp("sltu",   rIr(7'h00, 3'd3, 5'd9),  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        runOp("xor",    rIr(7'h00, 3'd4, 5'd10), 32'hF0F0AAAA, 32'h0FF05555, 32'hFF00FFFF, 1'b0, 1);
        runOp("or",     rIr(7'h00, 3'd6, 5'd11), 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1);
        runOp("and",    rIr(7'h00, 3'd7, 5'd12), 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1);
        runOp("ill40",  rIr(7'h40, 3'd0, 5'd13), 32'd5,        32'd6,        32'd0,        1'b1, 1);
        runOp("ill20",  rIr(7'h20, 3'd1, 5'd14), 32'd5,        32'd6,        32'd0,        1'b1, 1);
        runOp("mulh",   rIr(7'h01, 3'd1, 5'd15), 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, XLEN+1);
        runOp("mulhu",  rIr(7'h01, 3'd3, 5'd16), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, XLEN+1);
        runOp("mul",    rIr(7'h01, 3'd0, 5'd17), 32'd3,        32'hFFFFFFFB, 32'hFFFFFFF1, 1'b0, XLEN+1);
        runOp("mulhsu", rIr(7'h01, 3'd2, 5'd18), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, XLEN+1);
        runOp("div",    rIr(7'h01, 3'd4, 5'd19), 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, XLEN+1);
        runOp("rem",    rIr(7'h01, 3'd6, 5'd20), 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, XLEN+1);
        runOp("divu",   rIr(7'h01, 3'd5, 5'd21), 32'd100,      32'd7,        32'd14,       1'b0, XLEN+1);
        runOp("remu",   rIr(7'h01, 3'd7, 5'd22), 32'd100,      32'd7,        32'd2,        1'b0, XLEN+1);
        runOp("divu0",  rIr(7'h01, 3'd5, 5'd23), 32'd1234,     32'd0,        32'hFFFFFFFF, 1'b0, 1);
        runOp("rem0",   rIr(7'h01, 3'd6, 5'd24), 32'hFFFFFF00, 32'd0,        32'hFFFFFF00, 1'b0, 1);
        runOp("divovf", rIr(7'h01, 3'd4, 5'd25), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        runOp("removf", rIr(7'h01, 3'd6, 5'd26), 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1);

        // Result held stable while the consumer stalls.
        @(negedge iCLK);
        iIR = rIr(7'h00, 3'd0, 5'd27); iRS1 = 32'd40; iRS2 = 32'd2; iVALID = 1'b1;
        @(posedge iCLK); #1;
        iVALID = 1'b0; iRS1 = 32'd0;
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", {31'd0, oVALID}, 32'd1);
            check("hold_res", oRESULT, 32'd42);
            check("hold_rd", {27'd0, oRD}, 32'd27);
            @(posedge iCLK); #1;
        end
        @(negedge iCLK); iREADY = 1'b1;
        @(posedge iCLK); #1;
        check("hold_drop", {31'd0, oVALID}, 32'd0);

        // Back-to-back ADDs, one per cycle.
        bbA[0] = 32'd10; bbA[1] = 32'd20; bbA[2] = 32'hFFFFFFFF; bbA[3] = 32'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            check("b2b_ready", {31'd0, oREADY}, 32'd1);
            iIR = rIr(7'h00, 3'd0, 5'(i + 1)); iRS1 = bbA[i]; iRS2 = 32'd1; iVALID = 1'b1;
            @(posedge iCLK); #1;
            check("b2b_valid", {31'd0, oVALID}, 32'd1);
            check("b2b_res", oRESULT, bbA[i] + 32'd1);
            check("b2b_rd", {27'd0, oRD}, i + 1);
        end
        @(negedge iCLK); iVALID = 1'b0;
        @(posedge iCLK); #1;
        check("b2b_idle", {31'd0, oVALID}, 32'd0);
        iREADY = 1'b0;

        // Flush at cycle 10 of a DIV: no result may ever appear.
        @(negedge iCLK);
        iIR = rIr(7'h01, 3'd4, 5'd9); iRS1 = 32'd1000; iRS2 = 32'd3; iVALID = 1'b1;
        @(posedge iCLK); #1; iVALID = 1'b0;
        repeat (9) @(posedge iCLK);
        @(negedge iCLK); iFLUSH = 1'b1;
        iIR = rIr(7'h00, 3'd0, 5'd1); iVALID = 1'b1;
        @(negedge iCLK); iFLUSH = 1'b0; iVALID = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge iCLK); #1;
            if (oVALID) seen++;
        end
        check("flush_novalid", seen, 0);
        check("flush_ready", {31'd0, oREADY}, 32'd1);

        // Flush in IDLE with a valid op presented: the op is dropped.
        @(negedge iCLK);
        iIR = rIr(7'h00, 3'd0, 5'd2); iRS1 = 32'd1; iRS2 = 32'd1; iVALID = 1'b1; iFLUSH = 1'b1;
        @(posedge iCLK); #1;
        iVALID = 1'b0; iFLUSH = 1'b0;
        check("flush_drop", {31'd0, oVALID}, 32'd0);

        // Async reset mid-MUL.
        @(negedge iCLK);
        iIR = rIr(7'h01, 3'd0, 5'd30); iRS1 = 32'd6; iRS2 = 32'd7; iVALID = 1'b1;
        @(posedge iCLK); #1; iVALID = 1'b0;
        repeat (5) @(posedge iCLK);
        #2 iRST_N = 1'b0;
        #1;
        check("arst_valid", {31'd0, oVALID}, 32'd0);
        check("arst_ready", {31'd0, oREADY}, 32'd1);
        check("arst_res", oRESULT, 32'd0);
        check("arst_rd", {27'd0, oRD}, 32'd0);
        @(negedge iCLK); iRST_N = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge iCLK); #1;
            if (oVALID) seen++;
        end
        check("arst_novalid", seen, 0);

        runOp("post_rst", rIr(7'h00, 3'd0, 5'd31), 32'd2, 32'd3, 32'd5, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
